// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encodings and width helper shared by the UART TX path
package uart_pkg;
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] S_ACCEPT = 2'd1;
  localparam logic [STATE_W-1:0] S_START  = 2'd2;
  localparam logic [STATE_W-1:0] S_WAIT   = 2'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// rr_pick: first asserted request at or after the round-robin pointer, searched cyclically
module rr_pick import uart_pkg::*; #(
  parameter int N = 4,
  localparam int IW = clog2(N),
  localparam int SW = IW + 1
) (
  input  logic [N-1:0]  req_valid_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);
  logic [N-1:0]  rot;
  logic [SW-1:0] off;
  logic [SW-1:0] sum;
  assign rot   = N'({req_valid_i, req_valid_i} >> rr_ptr_i);
  assign any_o = |req_valid_i;
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? SW'(k) : off;
  end
  assign sum   = off + {1'b0, rr_ptr_i};
  assign idx_o = sum >= SW'(N) ? IW'(sum - SW'(N)) : sum[IW-1:0];
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among N_REQ byte sources
module uart_tx_sched import uart_pkg::*; #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int MAX_BURST   = 4,
  parameter int TIMEOUT_CYC = 2048,
  localparam int IW = clog2(N_REQ),
  localparam int BW = clog2(MAX_BURST + 1),
  localparam int WW = clog2(TIMEOUT_CYC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic                    tx_start_o,
  input  logic                    tx_done_i,
  output logic [IW-1:0]           grant_id_o,
  output logic                    active_o,
  output logic                    err_timeout_o
);
  logic [STATE_W-1:0] state_q, state_d;
  logic [IW-1:0]      grant_q, grant_d, ptr_q, ptr_d, pick;
  logic [BW-1:0]      burst_q, burst_d;
  logic [WW-1:0]      wdog_q, wdog_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic               start_q, start_d, any, g_valid, expire, rel;
  rr_pick #(.N(N_REQ)) u_pick (
    .req_valid_i(req_valid_i),
    .rr_ptr_i   (ptr_q),
    .any_o      (any),
    .idx_o      (pick)
  );
  assign g_valid = req_valid_i[grant_q];
  assign expire  = (state_q == S_WAIT) && (wdog_q == WW'(TIMEOUT_CYC - 1)) && !tx_done_i;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    burst_d = burst_q;
    wdog_d  = wdog_q;
    data_d  = data_q;
    rel     = 1'b0;
    case (state_q)
      S_IDLE: if (any) begin
        grant_d = pick;
        state_d = S_ACCEPT;
      end
      S_ACCEPT: if (g_valid) begin
        data_d  = req_data_i[grant_q*DATA_W +: DATA_W];
        burst_d = burst_q + 1'b1;
        state_d = S_START;
      end else rel = 1'b1;
      S_START: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      default: begin
        wdog_d = wdog_q + 1'b1;
        if (tx_done_i) begin
          if (burst_q < BW'(MAX_BURST) && g_valid) state_d = S_ACCEPT;
          else rel = 1'b1;
        end else rel = expire;
      end
    endcase
    ptr_d   = rel ? (grant_q == IW'(N_REQ - 1) ? '0 : grant_q + 1'b1) : ptr_q;
    burst_d = rel ? '0 : burst_d;
    state_d = rel ? S_IDLE : state_d;
    ready_d = state_d == S_ACCEPT ? N_REQ'(1) << grant_d : '0;
    start_d = state_d == S_START;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      wdog_q  <= '0;
      data_q  <= '0;
      ready_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      wdog_q  <= wdog_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      start_q <= start_d;
    end
  end
  assign req_ready_o   = ready_q;
  assign tx_data_o     = data_q;
  assign tx_start_o    = start_q;
  assign grant_id_o    = grant_q;
  assign active_o      = state_q != S_IDLE;
  assign err_timeout_o = expire;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench checking uart_tx_sched against a queue-level round-robin model
module tb_uart_tx_sched;
  localparam int N = 4, DW = 8, MB = 4, TO = 16;
  logic clk = 1'b0, rst = 1'b0, tx_done = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0] req_ready_o;
  logic [DW-1:0] tx_data_o;
  logic tx_start_o, active_o, err_timeout_o;
  logic [1:0] grant_id_o;
  typedef struct {int g; logic [DW-1:0] d;} exp_t;
  exp_t exp_q[$];
  logic [DW-1:0] bq[N][$];
  int n_cmp = 0, n_err = 0, cyc = 0, mptr = 0, done_dly = -1;
  int start_cnt = 0, err_cnt = 0, last_ready_cyc = -1, last_start_cyc = -1, last_err_cyc = -1;
  uart_tx_sched #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready_o), .tx_data_o(tx_data_o), .tx_start_o(tx_start_o),
    .tx_done_i(tx_done), .grant_id_o(grant_id_o), .active_o(active_o),
    .err_timeout_o(err_timeout_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = bq[i].size() != 0;
      req_data[i*DW +: DW] = '0;
      if (bq[i].size() != 0) req_data[i*DW +: DW] = bq[i][0];
    end
  endtask
  // Expected byte order: pick the first non-empty source from the pointer, drain up to MB bytes, rotate.
  task automatic model();
    logic [DW-1:0] mq[N][$];
    exp_t e;
    int g;
    for (int i = 0; i < N; i++) mq[i] = bq[i];
    forever begin
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && mq[(mptr + k) % N].size() != 0) g = (mptr + k) % N;
      if (g < 0) break;
      for (int n = 0; n < MB && mq[g].size() != 0; n++) begin
        e.g = g;
        e.d = mq[g].pop_front();
        exp_q.push_back(e);
      end
      mptr = (g + 1) % N;
    end
  endtask
  task automatic sync();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    sync();
    rst = 1'b1;
    for (int i = 0; i < N; i++) bq[i].delete();
    exp_q.delete();
    mptr = 0;
    drive();
    #1 check("reset_outputs", 32'({req_ready_o, tx_data_o, tx_start_o, grant_id_o, active_o, err_timeout_o}), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || active_o) && n < 3000);
    @(negedge clk);
    check("idle_in_time", 32'(active_o), 0);
    check("exp_drained", exp_q.size(), 0);
  endtask
  task automatic push(input int i, input logic [DW-1:0] d);
    bq[i].push_back(d);
  endtask
  task automatic go();
    model();
    drive();
  endtask
  // Source side: a byte leaves its queue after the cycle in which its ready was shown.
  always @(negedge clk) begin
    logic [N-1:0] acc;
    acc = req_ready_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i] && bq[i].size() != 0) void'(bq[i].pop_front());
    drive();
  end
  initial forever begin
    int d;
    @(negedge clk);
    if (tx_start_o && done_dly != 0) begin
      d = done_dly < 0 ? int'($urandom_range(1, 12)) : done_dly;
      repeat (d) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end
  always @(negedge clk) if (!rst) begin
    exp_t e;
    if (req_ready_o != '0) begin
      last_ready_cyc = cyc;
      check("ready_onehot", 32'(req_ready_o), 32'(1) << grant_id_o);
    end
    if (tx_start_o) begin
      start_cnt++;
      last_start_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_start", 32'(tx_start_o), 0);
      else begin
        e = exp_q.pop_front();
        check("start_grant", 32'(grant_id_o), e.g);
        check("start_data", 32'(tx_data_o), 32'(e.d));
      end
    end
    if (err_timeout_o) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end
  initial begin
    int t, s0, e0, n;
    do_reset();
    sync();
    tx_done = 1'b1;
    sync();
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_done_start", start_cnt, 0);
    check("stray_done_active", 32'(active_o), 0);
    done_dly = 5;
    sync();
    t = cyc;
    push(1, 8'hA5);
    go();
    wait_idle();
    check("t1_ready_lat", last_ready_cyc, t + 1);
    check("t1_start_lat", last_start_cyc, t + 2);
    check("t1_ptr", 32'(dut.ptr_q), 2);
    do_reset();
    done_dly = 10;
    s0 = start_cnt;
    sync();
    for (int i = 0; i < N; i++) push(i, 8'(8'h10 + i));
    go();
    wait_idle();
    sync();
    push(0, 8'h20);
    go();
    wait_idle();
    check("t2_starts", start_cnt - s0, 5);
    do_reset();
    done_dly = -1;
    s0 = start_cnt;
    sync();
    for (int i = 0; i < 6; i++) push(0, 8'(8'h30 + i));
    push(2, 8'h3F);
    go();
    wait_idle();
    check("t3_starts", start_cnt - s0, 7);
    do_reset();
    done_dly = 0;
    e0 = err_cnt;
    sync();
    t = cyc;
    push(1, 8'h41);
    push(2, 8'h42);
    go();
    wait_idle();
    check("t4_err_count", err_cnt - e0, 2);
    check("t4_next_start", last_start_cyc, t + 21);
    check("t4_err_lat", last_err_cyc, last_start_cyc + 16);
    done_dly = 15;
    sync();
    push(3, 8'h43);
    go();
    wait_idle();
    check("t4_done15_no_err", err_cnt - e0, 2);
    done_dly = 16;
    sync();
    push(0, 8'h44);
    go();
    wait_idle();
    check("t4_tie_no_err", err_cnt - e0, 2);
    do_reset();
    done_dly = 3;
    sync();
    push(2, 8'h52);
    go();
    wait_idle();
    done_dly = 0;
    s0 = start_cnt;
    sync();
    push(3, 8'h53);
    go();
    n = 0;
    while (start_cnt == s0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_started", start_cnt - s0, 1);
    repeat (3) @(negedge clk);
    do_reset();
    s0 = start_cnt;
    repeat (3) @(posedge clk);
    #2 tx_done = 1'b1;
    @(posedge clk);
    #2 tx_done = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_no_start", start_cnt - s0, 0);
    check("t5_inactive", 32'(active_o), 0);
    done_dly = -1;
    sync();
    push(1, 8'h61);
    push(3, 8'h63);
    go();
    wait_idle();
    sync();
    push(1, 8'h64);
    go();
    wait_idle();
    s0 = start_cnt;
    sync();
    push(3, 8'h73);
    drive();
    sync();
    bq[3].delete();
    drive();
    @(negedge clk);
    check("t6_ready_shown", 32'(req_ready_o), 32'h8);
    @(negedge clk);
    check("t6_inactive", 32'(active_o), 0);
    repeat (3) @(negedge clk);
    check("t6_no_start", start_cnt - s0, 0);
    check("t6_ptr", 32'(dut.ptr_q), 0);
    mptr = 0;
    sync();
    push(2, 8'h82);
    push(0, 8'h80);
    go();
    wait_idle();
    for (int r = 0; r < 15; r++) begin
      sync();
      for (int i = 0; i < N; i++) begin
        n = int'($urandom_range(0, 5));
        for (int j = 0; j < n; j++) push(i, 8'($urandom));
      end
      go();
      wait_idle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
